// File: rtl/ifu_axi_rd_bridge.sv
// ---------------------------------------------------------------------------
// ifu_axi_rd_bridge
//
// Purpose:
//   Converts a single-beat instruction-fetch read request (byte address plus
//   byte-mask size) into one AXI4 read transaction (AR then R channel), and
//   holds the returned 64-bit beat until the fetch unit consumes it. Only one
//   transaction is ever outstanding. Returned data is passed through unshifted;
//   the consumer selects the 32-bit half it needs from its own address bit 2.
//   The bridge has no flush input and always completes every accepted request.
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   rx_r_*           fetch request channel (valid/ready, addr, byte-mask size)
//   rx_data_*        response to fetch unit (data, valid/ready, rx_err_o)
//   ar*              AXI4 read-address channel (single beat, INCR, fixed ID)
//   r*               AXI4 read-data channel
// ---------------------------------------------------------------------------
module ifu_axi_rd_bridge #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int AXI_ID = 0
) (
  input  logic              clk,
  input  logic              rst,
  // fetch request
  input  logic              rx_r_valid_i,
  output logic              rx_r_ready_o,
  input  logic [ADDR_W-1:0] rx_r_addr_i,
  input  logic [7:0]        rx_r_size_i,
  // fetch response
  output logic [DATA_W-1:0] rx_data_read_o,
  output logic              rx_data_valid,
  input  logic              rx_data_ready,
  output logic              rx_err_o,
  // AXI read address channel
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  output logic [3:0]        arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  // AXI read data channel
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_RD,
    S_RESP
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] size;
  } size_dec_t;

  localparam logic [3:0] ARID = 4'(AXI_ID);

  state_t    state;
  size_dec_t req_dec;

  // Single-beat, fixed-ID, incrementing bursts only.
  assign arid    = ARID;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;

  // Byte mask to AXI arsize (log2 of bytes); any other mask is illegal.
  always_comb begin
    req_dec = '{legal: 1'b1, size: 3'd0};
    case (rx_r_size_i)
      8'h01:   req_dec.size = 3'd0;
      8'h03:   req_dec.size = 3'd1;
      8'h0F:   req_dec.size = 3'd2;
      8'hFF:   req_dec.size = 3'd3;
      default: req_dec.legal = 1'b0;
    endcase
  end

  // All outputs are registered and change only on state transitions, so each
  // channel's payload is naturally held stable while its valid is waiting.
  // NOTE: non-blocking assignments throughout, so every branch sees the
  // pre-edge values of state and outputs regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it only takes effect on a clock edge, and
    // any AXI transaction in flight is simply abandoned.
    if (rst) begin
      state          <= S_IDLE;
      rx_r_ready_o   <= 1'b1;
      arvalid        <= 1'b0;
      rready         <= 1'b0;
      rx_data_valid  <= 1'b0;
      rx_data_read_o <= '0;
      rx_err_o       <= 1'b0;
      araddr         <= '0;
      arsize         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_r_valid_i) begin
            rx_r_ready_o <= 1'b0;
            araddr       <= rx_r_addr_i;
            arsize       <= req_dec.size;
            if (req_dec.legal) begin
              arvalid <= 1'b1;
              state   <= S_AR;
            end else begin
              // Illegal mask: answer locally with an error, no AXI traffic.
              rx_data_read_o <= '0;
              rx_err_o       <= 1'b1;
              rx_data_valid  <= 1'b1;
              state          <= S_RESP;
            end
          end
        end

        S_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_RD;
          end
        end

        S_RD: begin
          // rready is only high here, so a beat offered during the AR
          // handshake cycle is ignored and taken once we reach RD.
          if (rvalid) begin
            rready         <= 1'b0;
            rx_data_read_o <= rdata;
            rx_err_o       <= (rresp != 2'b00) | ~rlast;
            rx_data_valid  <= 1'b1;
            state          <= S_RESP;
          end
        end

        S_RESP: begin
          if (rx_data_ready) begin
            rx_data_valid <= 1'b0;
            rx_r_ready_o  <= 1'b1;
            state         <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_axi_rd_bridge.sv
// ---------------------------------------------------------------------------
// tb_ifu_axi_rd_bridge
//
// Self-checking bench for ifu_axi_rd_bridge. The bench plays both the fetch
// unit and the AXI slave. Expected responses are pushed to a scoreboard queue
// when a request is issued and popped at the response handshake. Inputs are
// driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_ifu_axi_rd_bridge;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_r_valid_i = 1'b0;
  logic              rx_r_ready_o;
  logic [ADDR_W-1:0] rx_r_addr_i = '0;
  logic [7:0]        rx_r_size_i = '0;
  logic [DATA_W-1:0] rx_data_read_o;
  logic              rx_data_valid;
  logic              rx_data_ready = 1'b0;
  logic              rx_err_o;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready = 1'b0;
  logic [3:0]        arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [DATA_W-1:0] rdata = '0;
  logic [1:0]        rresp = '0;
  logic              rlast = 1'b0;
  logic              rvalid = 1'b0;
  logic              rready;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ifu_axi_rd_bridge #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .AXI_ID(0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_r_valid_i  (rx_r_valid_i),
    .rx_r_ready_o  (rx_r_ready_o),
    .rx_r_addr_i   (rx_r_addr_i),
    .rx_r_size_i   (rx_r_size_i),
    .rx_data_read_o(rx_data_read_o),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .rx_err_o      (rx_err_o),
    .araddr        (araddr),
    .arvalid       (arvalid),
    .arready       (arready),
    .arid          (arid),
    .arlen         (arlen),
    .arsize        (arsize),
    .arburst       (arburst),
    .rdata         (rdata),
    .rresp         (rresp),
    .rlast         (rlast),
    .rvalid        (rvalid),
    .rready        (rready)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch: request, optional AR/R/response backpressure, and
  // scoreboard comparison at the response handshake. With hold_next set the
  // requester keeps a second request asserted from the cycle after acceptance.
  task automatic fetch(input string tag, input logic [ADDR_W-1:0] addr,
                       input logic [7:0] size, input int ar_wait,
                       input int r_wait, input int d_wait,
                       input logic [DATA_W-1:0] data, input logic [1:0] resp,
                       input logic last, input bit early_r, input bit hold_next,
                       input logic [ADDR_W-1:0] next_addr,
                       input logic [7:0] next_size);
    int                guard;
    logic              legal;
    logic [2:0]        exp_sz;
    exp_t              e;
    exp_t              got;
    logic [DATA_W-1:0] held;
    logic              held_err;

    guard = 0;
    while (rx_r_ready_o !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    n_checks++;
    if (rx_r_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s req_ready_timeout: got %b want 1", tag, rx_r_ready_o);
    end

    legal = 1'b1;
    case (size)
      8'h01:   exp_sz = 3'd0;
      8'h03:   exp_sz = 3'd1;
      8'h0F:   exp_sz = 3'd2;
      8'hFF:   exp_sz = 3'd3;
      default: begin exp_sz = 3'd0; legal = 1'b0; end
    endcase
    e.data = legal ? data : '0;
    e.err  = !legal || (resp != 2'b00) || !last;
    sb.push_back(e);

    // NOTE: bench drives inputs with blocking assignments #1 after the edge,
    // so the DUT samples them cleanly on the following edge.
    rx_r_valid_i = 1'b1;
    rx_r_addr_i  = addr;
    rx_r_size_i  = size;
    step();
    if (hold_next) begin
      rx_r_addr_i = next_addr;
      rx_r_size_i = next_size;
    end else begin
      rx_r_valid_i = 1'b0;
    end
    n_checks++;
    if (rx_r_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s req_ready_after_accept: got %b want 0", tag, rx_r_ready_o);
    end

    if (legal) begin
      n_checks++;
      if ({arvalid, araddr, arsize, arlen, arburst, arid} !==
          {1'b1, addr, exp_sz, 8'd0, 2'b01, 4'd0}) begin
        n_fail++;
        $display("FAIL %s ar_issue: got v=%b a=%h sz=%0d len=%0d bur=%0d id=%0d want v=1 a=%h sz=%0d len=0 bur=1 id=0",
                 tag, arvalid, araddr, arsize, arlen, arburst, arid, addr, exp_sz);
      end
      repeat (ar_wait) begin
        step();
        n_checks++;
        if ({arvalid, araddr, arsize, rx_r_ready_o, rready} !== {1'b1, addr, exp_sz, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL %s ar_hold: got v=%b a=%h sz=%0d rdy=%b rready=%b want v=1 a=%h sz=%0d rdy=0 rready=0",
                   tag, arvalid, araddr, arsize, rx_r_ready_o, rready, addr, exp_sz);
        end
      end
      arready = 1'b1;
      if (early_r) begin
        // Beat offered in the AR handshake cycle must not be taken.
        rvalid = 1'b1;
        rdata  = ~data;
        rresp  = 2'b10;
        rlast  = 1'b0;
      end
      step();
      arready = 1'b0;
      rvalid  = 1'b0;
      n_checks++;
      if ({arvalid, rready, rx_data_valid} !== 3'b010) begin
        n_fail++;
        $display("FAIL %s enter_rd: got arvalid=%b rready=%b dvalid=%b want 0 1 0",
                 tag, arvalid, rready, rx_data_valid);
      end
      repeat (r_wait) begin
        step();
        n_checks++;
        if ({rready, rx_data_valid, arvalid} !== 3'b100) begin
          n_fail++;
          $display("FAIL %s rd_wait: got rready=%b dvalid=%b arvalid=%b want 1 0 0",
                   tag, rready, rx_data_valid, arvalid);
        end
      end
      rvalid = 1'b1;
      rdata  = data;
      rresp  = resp;
      rlast  = last;
      step();
      rvalid = 1'b0;
      rdata  = '0;
      rresp  = 2'b00;
      rlast  = 1'b0;
      n_checks++;
      if ({rready, rx_data_valid} !== 2'b01) begin
        n_fail++;
        $display("FAIL %s enter_resp: got rready=%b dvalid=%b want 0 1",
                 tag, rready, rx_data_valid);
      end
    end else begin
      n_checks++;
      if ({arvalid, rready, rx_data_valid} !== 3'b001) begin
        n_fail++;
        $display("FAIL %s illegal_resp: got arvalid=%b rready=%b dvalid=%b want 0 0 1",
                 tag, arvalid, rready, rx_data_valid);
      end
    end

    held     = rx_data_read_o;
    held_err = rx_err_o;
    repeat (d_wait) begin
      step();
      n_checks++;
      if ({rx_data_valid, rx_data_read_o, rx_err_o, rx_r_ready_o, arvalid} !==
          {1'b1, held, held_err, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL %s resp_hold: got v=%b d=%h e=%b rdy=%b arvalid=%b want v=1 d=%h e=%b rdy=0 arvalid=0",
                 tag, rx_data_valid, rx_data_read_o, rx_err_o, rx_r_ready_o, arvalid, held, held_err);
      end
    end

    rx_data_ready = 1'b1;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard_empty: got 0 entries want >=1", tag);
    end else begin
      got = sb.pop_front();
      if ({rx_data_read_o, rx_err_o} !== {got.data, got.err}) begin
        n_fail++;
        $display("FAIL %s resp_data: got d=%h e=%b want d=%h e=%b",
                 tag, rx_data_read_o, rx_err_o, got.data, got.err);
      end
    end
    step();
    rx_data_ready = 1'b0;
    n_checks++;
    if ({rx_data_valid, rx_r_ready_o, arvalid, rready} !== 4'b0100) begin
      n_fail++;
      $display("FAIL %s back_to_idle: got dvalid=%b rdy=%b arvalid=%b rready=%b want 0 1 0 0",
               tag, rx_data_valid, rx_r_ready_o, arvalid, rready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({rx_r_ready_o, arvalid, rready, rx_data_valid, rx_err_o} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset ctrl: got rdy=%b arvalid=%b rready=%b dvalid=%b err=%b want 1 0 0 0 0",
               rx_r_ready_o, arvalid, rready, rx_data_valid, rx_err_o);
    end
    n_checks++;
    if ({rx_data_read_o, araddr, arsize} !== {64'd0, 64'd0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset data: got d=%h a=%h sz=%0d want 0 0 0", rx_data_read_o, araddr, arsize);
    end
    n_checks++;
    if ({arid, arlen, arburst} !== {4'd0, 8'd0, 2'b01}) begin
      n_fail++;
      $display("FAIL reset consts: got id=%0d len=%0d bur=%0d want 0 0 1", arid, arlen, arburst);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    fetch("single", 64'h8000_0000, 8'h0F, 0, 0, 0, 64'h00000013_00100093,
          2'b00, 1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_sizes();
    fetch("size_01", 64'h8000_0101, 8'h01, 0, 1, 0, 64'h1111_2222_3333_4444,
          2'b00, 1'b1, 1'b0, 1'b0, '0, '0);
    fetch("size_03", 64'h8000_0202, 8'h03, 1, 0, 1, 64'hA5A5_5A5A_0F0F_F0F0,
          2'b00, 1'b1, 1'b0, 1'b0, '0, '0);
    fetch("size_ff", 64'hFFFF_FFFF_FFFF_FFF8, 8'hFF, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF,
          2'b00, 1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_backpressure();
    fetch("backpressure", 64'h8000_0040, 8'h0F, 3, 2, 4, 64'hDEAD_BEEF_CAFE_F00D,
          2'b00, 1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_error();
    fetch("err_slverr", 64'h8000_0080, 8'h0F, 0, 0, 1, 64'h0123_4567_89AB_CDEF,
          2'b10, 1'b1, 1'b0, 1'b0, '0, '0);
    fetch("err_nolast", 64'h8000_0088, 8'h0F, 1, 1, 0, 64'hFEDC_BA98_7654_3210,
          2'b00, 1'b0, 1'b0, 1'b0, '0, '0);
    fetch("early_rvalid", 64'h8000_0090, 8'hFF, 0, 0, 0, 64'h0000_0073_0000_0013,
          2'b00, 1'b1, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic test_illegal();
    fetch("illegal_07", 64'h8000_00A0, 8'h07, 0, 0, 0, 64'h5555_5555_5555_5555,
          2'b00, 1'b1, 1'b0, 1'b0, '0, '0);
    fetch("illegal_00", 64'h8000_00A8, 8'h00, 0, 0, 2, 64'h6666_6666_6666_6666,
          2'b00, 1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_back_to_back();
    fetch("b2b_first", 64'h8000_0000, 8'h0F, 0, 0, 0, 64'h00000013_00100093,
          2'b00, 1'b1, 1'b0, 1'b1, 64'h8000_0004, 8'h0F);
    fetch("b2b_second", 64'h8000_0004, 8'h0F, 0, 0, 0, 64'h00200113_00000013,
          2'b00, 1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_mid_rd();
    n_checks++;
    if (rx_r_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rd idle_before: got rdy=%b want 1", rx_r_ready_o);
    end
    rx_r_valid_i = 1'b1;
    rx_r_addr_i  = 64'h8000_0100;
    rx_r_size_i  = 8'h0F;
    step();
    rx_r_valid_i = 1'b0;
    arready      = 1'b1;
    step();
    arready = 1'b0;
    n_checks++;
    if ({rready, arvalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_rd in_rd: got rready=%b arvalid=%b want 1 0", rready, arvalid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({arvalid, rready, rx_data_valid, rx_r_ready_o} !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_rd ctrl: got arvalid=%b rready=%b dvalid=%b rdy=%b want 0 0 0 1",
               arvalid, rready, rx_data_valid, rx_r_ready_o);
    end
    n_checks++;
    if ({rx_data_read_o, rx_err_o} !== {64'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_rd data_cleared: got d=%h e=%b want 0 0", rx_data_read_o, rx_err_o);
    end
    fetch("after_reset", 64'h8000_0200, 8'h03, 0, 0, 0, 64'h0BAD_F00D_1234_5678,
          2'b00, 1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_sizes();
    test_backpressure();
    test_error();
    test_illegal();
    test_back_to_back();
    test_reset_mid_rd();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_axi_rd_bridge.md
Name: ifu_axi_rd_bridge

Overview:
- Upstream neighbour of the instruction-fetch stage. Accepts the fetch unit's single-beat read request (address + byte-mask size) and turns it into one AXI4 read transaction (AR + R channels).
- Holds the returned 64-bit beat until the fetch unit consumes it.
- Strictly one outstanding transaction; sits between the IF stage and the memory/AXI interconnect.

Parameters:
- ADDR_W, 64, request and AXI address width.
- DATA_W, 64, AXI read data width (one beat).
- AXI_ID, 0, constant value driven on arid.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_r_valid_i  input  1  fetch request valid.
- rx_r_ready_o  output  1  bridge can accept a request.
- rx_r_addr_i  input  ADDR_W  request byte address.
- rx_r_size_i  input  8  byte mask: 8'h01, 8'h03, 8'h0F or 8'hFF.
- rx_data_read_o  output  DATA_W  returned beat (full 64 bits, unshifted).
- rx_data_valid  output  1  rx_data_read_o valid.
- rx_data_ready  input  1  fetch unit accepts data.
- rx_err_o  output  1  error qualifier, valid with rx_data_valid.
- araddr  output  ADDR_W  AXI read address.
- arvalid  output  1  AXI read address valid.
- arready  input  1  AXI read address ready.
- arid  output  4  constant AXI_ID.
- arlen  output  8  constant 0.
- arsize  output  3  log2 of bytes.
- arburst  output  2  constant 2'b01 (INCR).
- rdata  input  DATA_W  AXI read data.
- rresp  input  2  AXI read response.
- rlast  input  1  AXI last beat.
- rvalid  input  1  AXI read data valid.
- rready  output  1  AXI read data ready.

Behaviour:
- **State machine:** IDLE, AR, RD, RESP; reset to IDLE.
- **Reset values:**
  - rx_r_ready_o=1 (IDLE); arvalid=0; rready=0; rx_data_valid=0.
  - rx_data_read_o=0; rx_err_o=0; araddr=0; arsize=0.
- **IDLE:**
  - rx_r_ready_o=1.
  - On rx_r_valid_i: latch address and size, then decode size to arsize (01→0, 03→1, 0F→2, FF→3).
  - Legal size → AR next cycle.
  - Illegal mask → RESP with rx_data_read_o=0, rx_err_o=1; no AXI traffic issued.
- **AR:**
  - arvalid=1; araddr and arsize are held stable until arready is sampled high.
  - On arvalid&&arready → RD; arvalid drops the following cycle.
- **RD:**
  - rready=1.
  - On rvalid: capture rdata into rx_data_read_o.
  - rx_err_o = (rresp!=2'b00) | ~rlast.
  - Go to RESP; rready drops.
- **RESP:**
  - rx_data_valid=1; rx_data_read_o and rx_err_o are held stable until rx_data_ready is sampled high, then IDLE.
  - rx_data_valid falls the cycle after the handshake.
- **rx_r_ready_o:** high only in IDLE. A request presented in any other state is not accepted and must be held by the requester.
- **Latency:** request accepted at edge N → arvalid high from N+1. With arready=1 and rvalid the cycle after the AR handshake, rx_data_valid is high from N+3.
- **Back-to-back:** no overlap. The next request can be accepted one cycle after the RESP handshake, i.e. the first IDLE cycle.
- **Data handling:**
  - No alignment or shifting; the consumer selects the 32-bit half from its own address bit 2.
  - Address is passed through unmodified.
- **Stale fetches:** no flush input. The consumer discards stale responses by comparing addresses; the bridge always completes every accepted request.
- **Reset mid-operation:**
  - Returns to IDLE immediately; all valids deasserted, latched data cleared.
  - Any in-flight AXI transaction is abandoned. Reset must therefore be applied system-wide together with the interconnect.
- **Simultaneous events:** rvalid asserted in the same cycle as the AR handshake is not sampled; rready is low in AR, so the beat is taken in RD.

Test Plan:
- **Single fetch:** rst for 2 cycles, then request addr 64'h80000000 size 8'h0F with arready=1 and rvalid=1 one cycle after AR.
  - araddr=64'h80000000, arsize=2, arlen=0.
  - rdata 64'h00000013_00100093 returned with rx_data_valid at N+3 and rx_err_o=0.
- **Backpressure both sides:** arready low for 3 cycles, then rx_data_ready low for 4 cycles after valid.
  - arvalid and araddr stable throughout the wait.
  - rx_data_read_o stable while rx_data_valid=1.
  - rx_r_ready_o=0 until the handshake completes.
- **Error response:** rresp=2'b10 with rlast=1 → rx_err_o=1 alongside data. Separately, rresp=0 with rlast=0 → rx_err_o=1.
- **Illegal size:** request size 8'h07 → no arvalid, rx_data_valid next cycle, data 0, rx_err_o=1.
- **Back-to-back:** addrs 64'h80000000 then 64'h80000004 requested continuously.
  - Second request is accepted only on the first IDLE cycle after the RESP handshake.
  - Two distinct AR transactions issued, both responses delivered in order.
- **Reset mid-RD:** assert rst while in RD → next cycle arvalid=0, rready=0, rx_data_valid=0, rx_r_ready_o=1.
